// File: rtl/nic_pkg.sv
// Shared types for the NIC host-port arbiter: FSM states, operation kinds, default byte width.
package nic_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    CAP  = 2'd3
  } state_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

endpackage

// File: rtl/nic_rr_pick.sv
// Combinational two-way round-robin select: a lone eligible requester wins,
// otherwise the requester named by rr_i wins.
module nic_rr_pick (
  input  logic [1:0] elig_i,
  input  logic       rr_i,
  output logic       winner_o,
  output logic       grant_valid_o
);

  always_comb begin
    grant_valid_o = |elig_i;
    winner_o      = rr_i;
    if (elig_i == 2'b01) begin
      winner_o = 1'b0;
    end else if (elig_i == 2'b10) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/nic_port_arbiter.sv
// Round-robin sharing of one UART NIC host port between two requesters.
// Optional per-requester grant counters are built when NIC_ARB_STATS_EN is defined.
module nic_port_arbiter
  import nic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef NIC_ARB_STATS_EN
  , parameter int CNT_W = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_wr_req,
  input  logic              r0_rd_req,
  input  logic [DATA_W-1:0] r0_wr_data,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rd_data,
  input  logic              r1_wr_req,
  input  logic              r1_rd_req,
  input  logic [DATA_W-1:0] r1_wr_data,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rd_data,
  output logic [DATA_W-1:0] send_data_to_nic,
  output logic              write_nic,
  output logic              read_nic,
  input  logic [DATA_W-1:0] rec_data_from_nic,
  input  logic              nic_tx_full,
  input  logic              nic_rx_empty,
  output logic              busy
`ifdef NIC_ARB_STATS_EN
  , output logic [CNT_W-1:0] r0_grant_cnt,
  output logic [CNT_W-1:0]   r1_grant_cnt
`endif
);

  state_e            state_q;
  logic              rr_q;
  logic              owner_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdd0_q;
  logic [DATA_W-1:0] rdd1_q;
  logic [DATA_W-1:0] send_q;
  logic              wr_q;
  logic              rd_q;
  logic              busy_q;

  logic [1:0]        wr_req;
  logic [1:0]        rd_req;
  logic [1:0]        el_wr;
  logic [1:0]        el_rd;
  logic [1:0]        elig;
  logic              winner;
  logic              grant_valid;
  op_e               win_op;
  logic [DATA_W-1:0] win_data;

  assign wr_req = {r1_wr_req, r0_wr_req};
  assign rd_req = {r1_rd_req, r0_rd_req};

  // A requester being acked this cycle is still showing its old request level.
  assign el_wr = wr_req & ~ack_q & {2{~nic_tx_full}};
  assign el_rd = rd_req & ~ack_q & {2{~nic_rx_empty}};
  assign elig  = el_wr | el_rd;

  nic_rr_pick u_pick (
    .elig_i        (elig),
    .rr_i          (rr_q),
    .winner_o      (winner),
    .grant_valid_o (grant_valid)
  );

  assign win_op   = el_wr[winner] ? OP_WR : OP_RD;
  assign win_data = winner ? r1_wr_data : r0_wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      ack_q   <= '0;
      rdd0_q  <= '0;
      rdd1_q  <= '0;
      send_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q <= winner;
            rr_q    <= ~winner;
            busy_q  <= 1'b1;
            if (win_op == OP_WR) begin
              state_q       <= WR;
              send_q        <= win_data;
              wr_q          <= 1'b1;
              ack_q[winner] <= 1'b1;
            end else begin
              state_q <= RD;
              rd_q    <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        WR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        RD: begin
          state_q <= CAP;
          busy_q  <= 1'b1;
        end
        CAP: begin
          // NIC read data is valid in this cycle, one cycle after read_nic.
          state_q        <= IDLE;
          busy_q         <= 1'b0;
          ack_q[owner_q] <= 1'b1;
          if (owner_q) begin
            rdd1_q <= rec_data_from_nic;
          end else begin
            rdd0_q <= rec_data_from_nic;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign r0_ack           = ack_q[0];
  assign r1_ack           = ack_q[1];
  assign r0_rd_data       = rdd0_q;
  assign r1_rd_data       = rdd1_q;
  assign send_data_to_nic = send_q;
  assign write_nic        = wr_q;
  assign read_nic         = rd_q;
  assign busy             = busy_q;

`ifdef NIC_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Counts settle one cycle after each ack pulse and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_q + CNT_W'(ack_q[0]);
      cnt1_q <= cnt1_q + CNT_W'(ack_q[1]);
    end
  end

  assign r0_grant_cnt = cnt0_q;
  assign r1_grant_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_nic_port_arbiter.sv
// Self-checking bench for nic_port_arbiter: timeline reference model plus directed literal checks.
module tb_nic_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_wr_req, r0_rd_req, r1_wr_req, r1_rd_req;
  logic [7:0] r0_wr_data, r1_wr_data;
  logic       r0_ack, r1_ack;
  logic [7:0] r0_rd_data, r1_rd_data;
  logic [7:0] send_data_to_nic;
  logic       write_nic, read_nic;
  logic [7:0] rec_data_from_nic;
  logic       nic_tx_full, nic_rx_empty;
  logic       busy;
`ifdef NIC_ARB_STATS_EN
  logic [3:0] r0_grant_cnt, r1_grant_cnt;
`endif

  always #5 clk = ~clk;

  nic_port_arbiter #(.DATA_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .r0_wr_req         (r0_wr_req),
    .r0_rd_req         (r0_rd_req),
    .r0_wr_data        (r0_wr_data),
    .r0_ack            (r0_ack),
    .r0_rd_data        (r0_rd_data),
    .r1_wr_req         (r1_wr_req),
    .r1_rd_req         (r1_rd_req),
    .r1_wr_data        (r1_wr_data),
    .r1_ack            (r1_ack),
    .r1_rd_data        (r1_rd_data),
    .send_data_to_nic  (send_data_to_nic),
    .write_nic         (write_nic),
    .read_nic          (read_nic),
    .rec_data_from_nic (rec_data_from_nic),
    .nic_tx_full       (nic_tx_full),
    .nic_rx_empty      (nic_rx_empty),
    .busy              (busy)
`ifdef NIC_ARB_STATS_EN
    , .r0_grant_cnt    (r0_grant_cnt),
    .r1_grant_cnt      (r1_grant_cnt)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  bit en          = 1'b0;

  // Reference model: a timeline of scheduled output events, indexed by cycle number.
  int   t         = 0;
  int   free_at   = 0;
  int   cap_t     = -1;
  int   cap_land  = -1;
  int   send_land = -1;
  bit   rr        = 1'b0;
  bit   cap_owner = 1'b0;
  bit   m_wr[8], m_rd[8], m_a0[8], m_a1[8], m_bz[8];
  logic [7:0] cap_val = 8'h00, send_val = 8'h00;
  logic [7:0] m_send = 8'h00, m_rdd0 = 8'h00, m_rdd1 = 8'h00;

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_wr[i] = 0; m_rd[i] = 0; m_a0[i] = 0; m_a1[i] = 0; m_bz[i] = 0;
    end
  end

  always @(negedge clk) begin
    int s, n1, n2, n3;
    bit e0, e1, w, w_is_wr, ok;
    s  = t % 8;
    n1 = (t + 1) % 8;
    n2 = (t + 2) % 8;
    n3 = (t + 3) % 8;
    if (send_land == t) m_send = send_val;
    if (cap_land == t) begin
      if (cap_owner) m_rdd1 = cap_val;
      else m_rdd0 = cap_val;
    end
    if (en) begin
      vectors++;
      ok = (r0_ack === m_a0[s]) && (r1_ack === m_a1[s]) && (write_nic === m_wr[s]) &&
           (read_nic === m_rd[s]) && (busy === m_bz[s]) && (send_data_to_nic === m_send) &&
           (r0_rd_data === m_rdd0) && (r1_rd_data === m_rdd1);
      if (!ok) begin
        miscompares++;
        $display("FAIL model cycle %0d: got ack=%b%b wr=%b rd=%b busy=%b send=%h rdd0=%h rdd1=%h; want ack=%b%b wr=%b rd=%b busy=%b send=%h rdd0=%h rdd1=%h",
                 t, r1_ack, r0_ack, write_nic, read_nic, busy, send_data_to_nic, r0_rd_data, r1_rd_data,
                 m_a1[s], m_a0[s], m_wr[s], m_rd[s], m_bz[s], m_send, m_rdd0, m_rdd1);
      end
    end
    e0 = ((r0_wr_req && !nic_tx_full) || (r0_rd_req && !nic_rx_empty)) && !m_a0[s];
    e1 = ((r1_wr_req && !nic_tx_full) || (r1_rd_req && !nic_rx_empty)) && !m_a1[s];
    m_wr[s] = 0; m_rd[s] = 0; m_a0[s] = 0; m_a1[s] = 0; m_bz[s] = 0;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_wr[i] = 0; m_rd[i] = 0; m_a0[i] = 0; m_a1[i] = 0; m_bz[i] = 0;
      end
      rr = 0; free_at = t + 1; m_send = 8'h00; m_rdd0 = 8'h00; m_rdd1 = 8'h00;
      cap_t = -1; cap_land = -1; send_land = -1;
    end else begin
      if (cap_t == t) begin
        cap_val  = rec_data_from_nic;
        cap_land = t + 1;
      end
      if (t >= free_at && (e0 || e1)) begin
        w       = (e0 && e1) ? rr : e1;
        w_is_wr = w ? (r1_wr_req && !nic_tx_full) : (r0_wr_req && !nic_tx_full);
        rr      = !w;
        m_bz[n1] = 1;
        if (w_is_wr) begin
          m_wr[n1] = 1;
          if (w) m_a1[n1] = 1; else m_a0[n1] = 1;
          send_val  = w ? r1_wr_data : r0_wr_data;
          send_land = t + 1;
          free_at   = t + 2;
        end else begin
          m_rd[n1]  = 1;
          m_bz[n2]  = 1;
          if (w) m_a1[n3] = 1; else m_a0[n3] = 1;
          cap_t     = t + 2;
          cap_owner = w;
          free_at   = t + 3;
        end
      end
    end
    t++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    r0_wr_req = 0; r0_rd_req = 0; r1_wr_req = 0; r1_rd_req = 0;
    tick();
    rst = 1'b0;
  endtask

  bit ack0_seen, ack1_seen;
  int k;

  initial begin
    rst = 1'b1;
    r0_wr_req = 0; r0_rd_req = 0; r1_wr_req = 0; r1_rd_req = 0;
    r0_wr_data = 8'h00; r1_wr_data = 8'h00;
    rec_data_from_nic = 8'h00; nic_tx_full = 0; nic_rx_empty = 0;
    tick();
    en = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_write_nic", write_nic, 0);
    chk("reset_r0_ack", r0_ack, 0);
    chk("reset_send", send_data_to_nic, 0);

    // single write
    rst = 1'b0;
    r0_wr_req = 1; r0_wr_data = 8'h5A;
    tick();
    chk("wr_write_nic", write_nic, 1);
    chk("wr_send", send_data_to_nic, 8'h5A);
    chk("wr_r0_ack", r0_ack, 1);
    chk("wr_busy", busy, 1);
    r0_wr_req = 0;
    tick();
    chk("wr_strobe_clear", write_nic, 0);
    chk("wr_busy_clear", busy, 0);

    // single read, NIC returns C3
    r0_rd_req = 1;
    tick();
    chk("rd_read_nic", read_nic, 1);
    rec_data_from_nic = 8'hC3;
    tick();
    chk("rd_strobe_clear", read_nic, 0);
    chk("rd_no_early_ack", r0_ack, 0);
    tick();
    chk("rd_r0_ack", r0_ack, 1);
    chk("rd_data", r0_rd_data, 8'hC3);
    chk("rd_r1_ack", r1_ack, 0);
    r0_rd_req = 0; rec_data_from_nic = 8'h00;
    tick();
    chk("rd_data_hold", r0_rd_data, 8'hC3);

    // both requesters writing continuously alternate
    do_reset();
    r0_wr_req = 1; r0_wr_data = 8'h11; r1_wr_req = 1; r1_wr_data = 8'h22;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("alt_write_nic", write_nic, (i % 2) == 1);
      if ((i % 2) == 1) chk("alt_send", send_data_to_nic, ((i % 4) == 1) ? 8'h11 : 8'h22);
    end
    r0_wr_req = 0; r1_wr_req = 0;

    // tx full holds off a pending write
    do_reset();
    nic_tx_full = 1; r1_wr_req = 1; r1_wr_data = 8'h77;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("full_no_write", write_nic, 0);
    end
    nic_tx_full = 0;
    tick();
    chk("full_release_write", write_nic, 1);
    chk("full_release_send", send_data_to_nic, 8'h77);
    chk("full_release_ack", r1_ack, 1);
    r1_wr_req = 0;

    // write beats read in the same requester, read follows
    do_reset();
    rec_data_from_nic = 8'hA5;
    r0_wr_req = 1; r0_rd_req = 1; r0_wr_data = 8'h3C;
    tick();
    chk("wr_first_write", write_nic, 1);
    chk("wr_first_read", read_nic, 0);
    tick();
    r0_wr_req = 0;
    tick();
    chk("rd_second_read", read_nic, 1);
    tick();
    tick();
    chk("rd_second_ack", r0_ack, 1);
    chk("rd_second_data", r0_rd_data, 8'hA5);
    r0_rd_req = 0;

    // reset during CAP aborts the read and restores rr=0
    do_reset();
    r0_rd_req = 1;
    tick();
    tick();
    rst = 1;
    tick();
    chk("rstcap_ack", r0_ack, 0);
    chk("rstcap_busy", busy, 0);
    rst = 0; r0_rd_req = 0;
    r0_wr_req = 1; r0_wr_data = 8'h01; r1_wr_req = 1; r1_wr_data = 8'h02;
    tick();
    chk("rstcap_rr_send", send_data_to_nic, 8'h01);
    chk("rstcap_rr_ack", r0_ack, 1);
    r0_wr_req = 0; r1_wr_req = 0;

`ifdef NIC_ARB_STATS_EN
    do_reset();
    r0_wr_req = 1; r0_wr_data = 8'h99;
    for (int i = 0; i < 16; i++) tick();
    tick();
    chk("cnt_half", r0_grant_cnt, 8);
    for (int i = 0; i < 15; i++) tick();
    r0_wr_req = 0;
    tick();
    tick();
    chk("cnt_wrap", r0_grant_cnt, 0);
    chk("cnt_r1", r1_grant_cnt, 0);
`endif

    // randomized traffic against the model
    do_reset();
    ack0_seen = 0; ack1_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      rst               = ($urandom_range(0, 299) == 0);
      nic_tx_full       = ($urandom_range(0, 3) == 0);
      nic_rx_empty      = ($urandom_range(0, 3) == 0);
      rec_data_from_nic = 8'($urandom);
      if (rst || ack0_seen) begin
        r0_wr_req = 0; r0_rd_req = 0;
      end else if (!r0_wr_req && !r0_rd_req && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        r0_wr_req = (k != 1); r0_rd_req = (k != 0); r0_wr_data = 8'($urandom);
      end
      if (rst || ack1_seen) begin
        r1_wr_req = 0; r1_rd_req = 0;
      end else if (!r1_wr_req && !r1_rd_req && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        r1_wr_req = (k != 1); r1_rd_req = (k != 0); r1_wr_data = 8'($urandom);
      end
      tick();
      ack0_seen = r0_ack;
      ack1_seen = r1_ack;
    end
    rst = 0;
    r0_wr_req = 0; r0_rd_req = 0; r1_wr_req = 0; r1_rd_req = 0;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
